match_stats: RTL and testbench

- Downstream consumer of the sequence detector's 1-bit match output (outp).
- Accumulates match statistics: a saturating total count, a per-window count with burst flag, and the gap between consecutive matches (last and minimum).
- Provides registered, pulse-qualified results to a host or status block.
- One clock domain. All state is registered.

---
 rtl/match_stats.sv | 167 ++++++++++++++++
 tb/tb_match_stats.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/match_stats.sv
// rtl/match_stats.sv - match statistics: saturating total, windowed burst count, inter-match gaps
module match_stats #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WIN_LEN = 16,
    parameter int unsigned THRESH  = 3,
    parameter int unsigned GAP_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_det,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_total_cnt,
    output logic [CNT_W-1:0] o_win_cnt,
    output logic             o_win_valid,
    output logic             o_burst,
    output logic [GAP_W-1:0] o_last_gap,
    output logic [GAP_W-1:0] o_min_gap,
    output logic             o_gap_valid
);

    localparam int unsigned        WCYC_W    = $clog2(WIN_LEN);
    localparam logic [WCYC_W-1:0]  WCYC_LAST = WCYC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [GAP_W-1:0]   GAP_MAX   = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } gap_state_t;

    logic [CNT_W-1:0]  r_total_cnt;
    logic [CNT_W-1:0]  r_win_cnt;
    logic              r_win_valid;
    logic              r_burst;
    logic [WCYC_W-1:0] r_wcyc;
    logic [CNT_W-1:0]  r_acc;
    gap_state_t        r_state;
    gap_state_t        w_state_next;
    logic [GAP_W-1:0]  r_gap_ctr;
    logic [GAP_W-1:0]  r_last_gap;
    logic [GAP_W-1:0]  r_min_gap;
    logic              r_gap_valid;

    logic [CNT_W-1:0]  w_total_inc;
    logic [CNT_W-1:0]  w_acc_next;
    logic              w_win_end;
    logic              w_thresh_hit;
    logic [GAP_W-1:0]  w_gap_inc;
    logic              w_gap_fire;

    assign w_total_inc  = (r_total_cnt == CNT_MAX) ? r_total_cnt : r_total_cnt + CNT_W'(1);
    assign w_acc_next   = (i_det && (r_acc != CNT_MAX)) ? r_acc + CNT_W'(1) : r_acc;
    assign w_win_end    = (r_wcyc == WCYC_LAST);
    assign w_thresh_hit = (32'(w_acc_next) >= THRESH);
    assign w_gap_inc    = (r_gap_ctr == GAP_MAX) ? r_gap_ctr : r_gap_ctr + GAP_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_total_cnt <= '0;
        end else if (i_clr) begin
            r_total_cnt <= '0;
        end else if (i_en && i_det) begin
            r_total_cnt <= w_total_inc;
        end
    end

    // The window-end cycle folds its own det into the closing window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wcyc      <= '0;
            r_acc       <= '0;
            r_win_cnt   <= '0;
            r_burst     <= 1'b0;
            r_win_valid <= 1'b0;
        end else if (i_clr) begin
            r_wcyc      <= '0;
            r_acc       <= '0;
            r_win_cnt   <= '0;
            r_burst     <= 1'b0;
            r_win_valid <= 1'b0;
        end else if (i_en) begin
            if (w_win_end) begin
                r_win_cnt   <= w_acc_next;
                r_burst     <= w_thresh_hit;
                r_win_valid <= 1'b1;
                r_acc       <= '0;
                r_wcyc      <= '0;
            end else begin
                r_acc       <= w_acc_next;
                r_wcyc      <= r_wcyc + WCYC_W'(1);
                r_win_valid <= 1'b0;
            end
        end else begin
            r_win_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else if (i_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_en && i_det) begin
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (i_en && i_det) begin
                    w_gap_fire = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Gap counter restarts at 0 on every match; a fired gap is counter+1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_ctr   <= '0;
            r_last_gap  <= '0;
            r_min_gap   <= GAP_MAX;
            r_gap_valid <= 1'b0;
        end else if (i_clr) begin
            r_gap_ctr   <= '0;
            r_last_gap  <= '0;
            r_min_gap   <= GAP_MAX;
            r_gap_valid <= 1'b0;
        end else if (i_en) begin
            r_gap_valid <= w_gap_fire;
            if (w_gap_fire) begin
                r_last_gap <= w_gap_inc;
                if (w_gap_inc < r_min_gap) begin
                    r_min_gap <= w_gap_inc;
                end
            end
            if ((r_state == S_ARMED) && !i_det) begin
                r_gap_ctr <= w_gap_inc;
            end else begin
                r_gap_ctr <= '0;
            end
        end else begin
            r_gap_valid <= 1'b0;
        end
    end

    assign o_total_cnt = r_total_cnt;
    assign o_win_cnt   = r_win_cnt;
    assign o_win_valid = r_win_valid;
    assign o_burst     = r_burst;
    assign o_last_gap  = r_last_gap;
    assign o_min_gap   = r_min_gap;
    assign o_gap_valid = r_gap_valid;

endmodule

// File: tb/tb_match_stats.sv
// tb/tb_match_stats.sv - randomized and directed bench for match_stats against a queue-free counting model
module tb_match_stats;

    localparam int CW   = 8;
    localparam int GW   = 8;
    localparam int TH   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int GMAX = (1 << GW) - 1;

    logic clk = 1'b0;
    logic rst_n, det, en, clr;

    logic [CW-1:0] a_total, a_win_cnt, b_total, b_win_cnt;
    logic          a_win_valid, a_burst, a_gap_valid;
    logic          b_win_valid, b_burst, b_gap_valid;
    logic [GW-1:0] a_last_gap, a_min_gap, b_last_gap, b_min_gap;

    always #5 clk = ~clk;

    match_stats #(.CNT_W(CW), .WIN_LEN(16), .THRESH(TH), .GAP_W(GW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_det(det), .i_en(en), .i_clr(clr),
        .o_total_cnt(a_total), .o_win_cnt(a_win_cnt), .o_win_valid(a_win_valid),
        .o_burst(a_burst), .o_last_gap(a_last_gap), .o_min_gap(a_min_gap),
        .o_gap_valid(a_gap_valid)
    );

    match_stats #(.CNT_W(CW), .WIN_LEN(300), .THRESH(TH), .GAP_W(GW)) u_dut_long (
        .i_clk(clk), .i_rst_n(rst_n), .i_det(det), .i_en(en), .i_clr(clr),
        .o_total_cnt(b_total), .o_win_cnt(b_win_cnt), .o_win_valid(b_win_valid),
        .o_burst(b_burst), .o_last_gap(b_last_gap), .o_min_gap(b_min_gap),
        .o_gap_valid(b_gap_valid)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int m_total, m_last_gap, m_min_gap, m_gv, m_idx, m_last_idx, m_seen;
    int m_wn[2], m_ws[2], m_wc[2], m_bu[2], m_wv[2];
    int wl[2];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic m_reset();
        m_total = 0; m_last_gap = 0; m_min_gap = GMAX; m_gv = 0;
        m_idx = 0; m_last_idx = 0; m_seen = 0;
        for (int k = 0; k < 2; k++) begin
            m_wn[k] = 0; m_ws[k] = 0; m_wc[k] = 0; m_bu[k] = 0; m_wv[k] = 0;
        end
    endtask

    // Model: windows are plain enabled-cycle tallies, gaps are index differences.
    task automatic m_clock();
        int g;
        if (clr) begin
            m_reset();
        end else if (en) begin
            m_gv = 0;
            if (det) m_total = imin(m_total + 1, CMAX);
            for (int k = 0; k < 2; k++) begin
                m_wv[k] = 0;
                m_ws[k] += int'(det);
                m_wn[k]++;
                if (m_wn[k] == wl[k]) begin
                    m_wc[k] = imin(m_ws[k], CMAX);
                    m_bu[k] = (m_wc[k] >= TH) ? 1 : 0;
                    m_wv[k] = 1;
                    m_ws[k] = 0;
                    m_wn[k] = 0;
                end
            end
            if (det) begin
                if (m_seen != 0) begin
                    g = imin(m_idx - m_last_idx, GMAX);
                    m_last_gap = g;
                    m_min_gap  = imin(m_min_gap, g);
                    m_gv = 1;
                end
                m_seen = 1;
                m_last_idx = m_idx;
            end
            m_idx++;
        end else begin
            m_wv[0] = 0; m_wv[1] = 0; m_gv = 0;
        end
    endtask

    task automatic check_all();
        chk("a_total", a_total, m_total);
        chk("a_win_cnt", a_win_cnt, m_wc[0]);
        chk("a_win_valid", a_win_valid, m_wv[0]);
        chk("a_burst", a_burst, m_bu[0]);
        chk("a_last_gap", a_last_gap, m_last_gap);
        chk("a_min_gap", a_min_gap, m_min_gap);
        chk("a_gap_valid", a_gap_valid, m_gv);
        chk("b_total", b_total, m_total);
        chk("b_win_cnt", b_win_cnt, m_wc[1]);
        chk("b_win_valid", b_win_valid, m_wv[1]);
        chk("b_burst", b_burst, m_bu[1]);
        chk("b_last_gap", b_last_gap, m_last_gap);
        chk("b_min_gap", b_min_gap, m_min_gap);
        chk("b_gap_valid", b_gap_valid, m_gv);
    endtask

    task automatic step(input logic d, input logic e, input logic c);
        @(negedge clk);
        det = d; en = e; clr = c;
        @(posedge clk);
        if (rst_n) m_clock();
        #1;
        check_all();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        wl[0] = 16; wl[1] = 300;
        m_reset();
        rst_n = 1'b0; det = 1'b0; en = 1'b1; clr = 1'b0;

        for (int i = 0; i < 6; i++) step(logic'(i % 2), 1'b1, 1'b0);
        chk("rst_total", a_total, 0);
        chk("rst_min_gap", a_min_gap, 255);
        chk("rst_win_valid", a_win_valid, 0);
        rst_n = 1'b1;

        step(1'b1, 1'b1, 1'b0);
        chk("first_total", a_total, 1);
        chk("first_gap_valid", a_gap_valid, 0);

        step(1'b0, 1'b1, 1'b1);
        for (int w = 0; w < 16; w++) step(logic'(w == 2 || w == 5 || w == 9), 1'b1, 1'b0);
        chk("win1_valid", a_win_valid, 1);
        chk("win1_cnt", a_win_cnt, 3);
        chk("win1_burst", a_burst, 1);
        for (int w = 0; w < 16; w++) step(logic'(w == 0 || w == 15), 1'b1, 1'b0);
        chk("win2_valid", a_win_valid, 1);
        chk("win2_cnt", a_win_cnt, 2);
        chk("win2_burst", a_burst, 0);

        step(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 15; c++) begin
            step(logic'(c == 10 || c == 13 || c == 14), 1'b1, 1'b0);
            if (c == 10) chk("gap_first_nopulse", a_gap_valid, 0);
            if (c == 13) begin
                chk("gap3_valid", a_gap_valid, 1);
                chk("gap3_last", a_last_gap, 3);
                chk("gap3_min", a_min_gap, 3);
            end
            if (c == 14) begin
                chk("gap1_last", a_last_gap, 1);
                chk("gap1_min", a_min_gap, 1);
            end
        end

        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0);
        chk("sat_total", a_total, 255);
        chk("sat_long_valid", b_win_valid, 1);
        chk("sat_long_win_cnt", b_win_cnt, 255);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("sat_gap", a_last_gap, 255);

        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(logic'(i == 3), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("en_hold_total", a_total, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 6) chk("en_not_yet", a_win_valid, 0);
        end
        chk("en_delayed_end", a_win_valid, 1);
        chk("en_win_cnt", a_win_cnt, 1);

        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_total", a_total, 0);
        chk("clr_min_gap", a_min_gap, 255);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_idle_no_gap", a_gap_valid, 0);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_total", a_total, 0);
        chk("async_min_gap", a_min_gap, 255);
        check_all();
        step(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++)
            step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 7) != 0),
                 logic'($urandom_range(0, 199) == 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
